// File: rtl/oled_spi_rx.sv
// Display SPI receiver: rebuilds 8-bit {DnC,data} bytes, valid 2 clocks after 8th SCLK sample, valid/ready out.
// Full output stage drops new bytes and pulses Overrun; define OLED_RX_FIFO_EN for a FIFO_DEPTH-entry output FIFO.
module oled_spi_rx #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       SCLK,
  input  logic       nCS,
  input  logic       DnC,
  input  logic       SDIN,
  output logic [7:0] RxData,
  output logic       RxDnC,
  output logic       RxValid,
  input  logic       RxReady,
  output logic       FrameErr,
  output logic       Overrun,
  output logic       Busy
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t     state_q, state_d;
  logic       sclk_q, sclk_qq, ncs_q, dnc_q, sdin_q;
  logic       armed_q, armed_d;
  logic [2:0] cnt_q, cnt_d;
  logic [6:0] sr_q, sr_d;
  logic       frame_err_q, frame_err_d;
  logic       overrun_q, overrun_d;
  logic       rise;
  logic       commit;
  logic [8:0] commit_word;

  // Pin samplers track the pins even in reset so armed_q sees the true nCS level on release.
  always_ff @(posedge Clock) begin
    sclk_q  <= SCLK;
    sclk_qq <= sclk_q;
    ncs_q   <= nCS;
    dnc_q   <= DnC;
    sdin_q  <= SDIN;
  end

  assign rise        = sclk_q & ~sclk_qq;
  assign commit_word = {dnc_q, sr_q, sdin_q};

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      armed_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      armed_q     <= armed_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    frame_err_d = 1'b0;
    commit      = 1'b0;
    // A frame already under way at reset release is skipped until nCS has been seen high.
    armed_d     = armed_q | ncs_q;
    case (state_q)
      IDLE: begin
        if (!ncs_q && armed_q) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (ncs_q) begin
          state_d     = IDLE;
          frame_err_d = (cnt_q != 3'd0);
          cnt_d       = '0;
        end else if (rise) begin
          sr_d   = {sr_q[5:0], sdin_q};
          cnt_d  = cnt_q + 3'd1;
          commit = (cnt_q == 3'd7);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign FrameErr = frame_err_q;
  assign Overrun  = overrun_q;
  assign Busy     = (state_q == SHIFT);

`ifdef OLED_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [8:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic        empty, full, push, pop;

  assign empty     = (wr_q == rd_q);
  assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop       = ~empty & RxReady;
  assign push      = commit & (~full | pop);
  assign overrun_d = commit & full & ~pop;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q[AW-1:0]] <= commit_word;
        wr_q                <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
    end
  end

  assign {RxDnC, RxData} = mem_q[rd_q[AW-1:0]];
  assign RxValid         = ~empty;
`else
  logic [8:0] hold_q;
  logic       vld_q;

  assign overrun_d = commit & vld_q & ~RxReady;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      hold_q <= '0;
      vld_q  <= 1'b0;
    end else if (commit && (!vld_q || RxReady)) begin
      hold_q <= commit_word;
      vld_q  <= 1'b1;
    end else if (vld_q && RxReady) begin
      vld_q <= 1'b0;
    end
  end

  assign {RxDnC, RxData} = hold_q;
  assign RxValid         = vld_q;
`endif

endmodule

// File: doc/oled_spi_rx.md
# oled_spi_rx

Serial-to-parallel receiver for the display SPI link (SCLK, nCS, DnC, SDIN) that the cycle computer core drives toward the OLED panel. It reassembles 8-bit command and data bytes, tagging each with its DnC level, and hands them out over a valid/ready handshake. It also flags framing errors and overruns. It sits on the receiving end of the link as a display-side front end and as the checking monitor in the chip-level bench.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: receive FIFO entries; power of two ≥2; used only when `OLED_RX_FIFO_EN` is defined.

Ports:
- `Clock`  in  1  system clock; all logic on its rising edge.
- `Reset`  in  1  synchronous reset, active-high.
- `SCLK`  in  1  serial clock; synchronous to `Clock`; idle low; high and low phases each ≥2 `Clock` cycles.
- `nCS`  in  1  chip select, active-low.
- `DnC`  in  1  1 = data byte, 0 = command byte.
- `SDIN`  in  1  serial data, MSB first.
- `RxData`  out  8  received byte.
- `RxDnC`  out  1  `DnC` level captured with the byte.
- `RxValid`  out  1  `RxData`/`RxDnC` valid.
- `RxReady`  in  1  consumer accepts; a transfer happens on a cycle with `RxValid & RxReady`.
- `FrameErr`  out  1  one-cycle pulse: `nCS` rose with a partial byte.
- `Overrun`  out  1  one-cycle pulse: a completed byte was dropped.
- `Busy`  out  1  high while the state is SHIFT.

## Operation
- Input stage: `SCLK`, `nCS`, `DnC` and `SDIN` are each registered once (`_q`); `SCLK` is registered a second time (`_qq`).
  - `rise = SCLK_q & ~SCLK_qq`.
  - All decisions use only the `_q` values.
- State machine, IDLE / SHIFT:
  - IDLE: `nCS_q` low → SHIFT; bit count is cleared to 0. A `rise` arriving in the same cycle as this transition is ignored.
  - SHIFT, on `rise` with `nCS_q` low: the shift register takes `{sr[6:0], SDIN_q}` and the 3-bit bit count increments.
  - SHIFT, on the 8th bit (count wraps 7→0): the byte `{sr[6:0], SDIN_q}` and `DnC_q` are committed to the output stage; the state stays SHIFT.
  - SHIFT, `nCS_q` high: → IDLE.
    - If the bit count ≠ 0, pulse `FrameErr` and discard the partial byte.
    - If `rise` occurs in the same cycle, the edge is ignored, since `nCS_q` is already high.
- Back-to-back bytes within one `nCS` low window are supported with no gap.
- `DnC` may change between bytes; only its level at the 8th `rise` is kept.
- Output stage without FIFO: a single holding register.
  - A commit while `RxValid & ~RxReady` drops the new byte, pulses `Overrun`, and keeps the old byte.
  - A commit in the same cycle as a transfer is accepted: the new byte replaces the old one and `RxValid` stays high.
- `Reset`:
  - State → IDLE; bit count, shift register and FIFO are cleared.
  - A reset in the middle of a byte discards it without a `FrameErr` pulse.
  - After `Reset` releases, reception resumes at the next falling edge of `nCS_q`. Bits of the frame already in progress are ignored.
- Output reset values: `RxData`=8'h00, `RxDnC`=0, `RxValid`=0, `FrameErr`=0, `Overrun`=0, `Busy`=0.

## Timing
- Let edge k be the `Clock` edge at which `SCLK_q` first goes high for the 8th bit.
  - The shift register and commit update at edge k+1.
  - `RxData`, `RxDnC` and `RxValid` are valid after edge k+1.
  - Latency from the edge at which `SCLK` is sampled high is 2 `Clock` edges. This holds in both configurations.
- `FrameErr` is high for the cycle after the edge at which `nCS_q` is sampled high.
- `Overrun` is high for the cycle after the rejected commit.
- `RxValid` drops after the transfer edge unless another entry is pending.
- `RxData` is held stable while `RxValid & ~RxReady`.
- Throughput: one byte per 8 `SCLK` periods; the minimum `SCLK` period is 4 `Clock` cycles.

## Configuration
- `OLED_RX_FIFO_EN` defined:
  - The output stage is a show-ahead FIFO of `FIFO_DEPTH` entries holding 9-bit `{DnC, data}` words; `RxData`/`RxDnC` present the head entry.
  - `Overrun` pulses only when a commit hits a full FIFO with no pop in that cycle.
  - A push and a pop in the same cycle on a full FIFO are both accepted.
  - Empty: `RxValid`=0.
- `OLED_RX_FIFO_EN` undefined: the single holding register described under Operation is used and `FIFO_DEPTH` is ignored.

## Test plan
- Single byte: `nCS` low, `DnC`=0, 8'hAF MSB first, `SCLK` period 8 → exactly one `RxValid` with `RxData`=8'hAF, `RxDnC`=0, 2 edges after the 8th rise is sampled.
- Burst: `DnC`=1, bytes 8'h00, 8'hFF, 8'h5A back-to-back in one `nCS` window, `RxReady`=1 → three transfers in order, all with `RxDnC`=1, no `FrameErr`.
- Framing: 5 bits then `nCS` high → `FrameErr` pulses once, `RxValid` stays 0; a following full byte 8'h3C is received correctly.
- Overrun with FIFO disabled: `RxReady`=0 and two bytes 8'h11, 8'h22 → `Overrun` pulses once and `RxData` stays 8'h11. With FIFO enabled and depth 4: five bytes → `Overrun` on the 5th only, and the first four pop out in order.
- Reset in the middle of a byte: `Reset` after 4 bits → all outputs at reset values, no `FrameErr`; the next `nCS` frame carrying 8'hC3 is received as 8'hC3.
- Same-cycle events: `SCLK` rise and `nCS` rise sampled on the same edge at bit 7 → edge ignored, `FrameErr`=1, no byte committed.
